lib_acc_round_sat: RTL and testbench
====================================

// Module: lib_acc_round_sat
// PURPOSE
//  Downstream consumer of the signed 8x26 multiplier (34-bit product).
//  Accumulates a programmable run of signed products into a wide register.
//  Rounds the sum (round-half-up), arithmetic-shifts it right by SHIFT and
//  saturates it to OUT_W bits. Returns the result over a valid/ready handshake.
//  Forms the multiply-accumulate tail of the datapath feeding the 26-bit domain.
// PARAMETERS
//  NP     34  signed product width (width of the multiplier output)
//  LEN_W  8   width of run-length port; max run = 2^LEN_W-1
//  ACC_W  42  accumulator width; must be >= NP+LEN_W (no internal overflow)
//  SHIFT  8   right shift applied after rounding; 0 = no shift, no rounding add
//  OUT_W  26  signed output width
// PORTS
//  clk       in   1      clock; all state updates on rising edge
//  rst       in   1      reset, synchronous, active-high
//  len       in   LEN_W  products per run; sampled on the first beat of a run
//  in_valid  in   1      in_prod is valid
//  in_ready  out  1      block accepts a product this cycle
//  in_prod   in   NP     signed product (two's complement)
//  out_valid out  1      out_data/out_sat are valid
//  out_ready in   1      downstream accepts the result
//  out_data  out  OUT_W  rounded, shifted, saturated signed sum
//  out_sat   out  1      1 = out_data was clipped to +max or -min
//  busy      out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Beat = in_valid & in_ready. out-handshake = out_valid & out_ready.
//  Reset: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, busy=0.
//    Beats presented while rst=1 are discarded.
//  in_ready = (state==IDLE)|(state==ACC). It is 0 in RND and OUT.
//  IDLE: on a beat, latch run length L=len (len==0 is treated as 1).
//    Set acc=sext(in_prod), cnt=1. Go to RND if L==1, else go to ACC.
//  ACC: on a beat, acc+=sext(in_prod), cnt+=1. Go to RND when cnt+1==L.
//    Gaps (in_valid=0) stall the run indefinitely with no effect.
//  RND (1 cycle): t = acc + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in ACC_W+1 bits.
//    r = t >>> SHIFT (arithmetic; floor).
//    If r > 2^(OUT_W-1)-1: out_data=+max, out_sat=1.
//    If r < -2^(OUT_W-1): out_data=-min, out_sat=1.
//    Otherwise out_data=r[OUT_W-1:0], out_sat=0.
//    Set out_valid=1 and go to OUT.
//  OUT: out_data/out_sat held stable while out_valid=1 and out_ready=0.
//    On out-handshake: out_valid=0, acc=0, go to IDLE.
//    The next run's first beat is accepted no earlier than the following cycle.
//  Latency: last beat accepted at edge t -> out_valid=1 after edge t+1.
//  Throughput: L+2 cycles per run minimum (out_ready held 1).
//  Ties round toward +inf: +1.5 -> 2, -1.5 -> -1, -2.5 -> -2.
//  len changes mid-run are ignored; L is fixed for the whole run.
//  rst mid-run or in OUT: run aborted, no result emitted, return to reset state.
// TESTING (SHIFT=8, OUT_W=26, defaults)
//  T1 len=1, prod=256, out_ready=1 -> out_data=1, out_sat=0.
//     out_valid is high the cycle after RND, for exactly 1 cycle.
//  T2 len=3, prods 100,-300,456 (sum 256) -> out_data=1.
//     len=2, prods 200,184 (384) -> 2. prods -200,-184 (-384) -> -1.
//  T3 len=4, prods each +2^32 -> out_data=0x1FFFFFF, out_sat=1.
//     prods each -2^32 -> out_data=0x2000000, out_sat=1.
//  T4 len=2, prod=512 twice, out_ready=0 for 5 cycles -> out_data=4 held.
//     in_ready=0 throughout; one result delivered on out_ready=1, then IDLE.
//  T5 len=4, rst asserted after beat 2 -> out_valid never rises.
//     Then len=1, prod=512 -> out_data=2 (acc is clean).
//  T6 len=0, prod=-256 -> run ends after 1 beat, out_data=-1.
//     In-run in_valid gaps of 3 cycles -> same sum as gap-free run.

Source files
------------

// File: rtl/lib_acc_round_sat.sv
// -----------------------------------------------------------------------------
// lib_acc_round_sat
//
// Multiply-accumulate tail. Sums a programmable run of signed products into a
// wide accumulator. Then rounds the sum half-up, arithmetic-shifts it right by
// SHIFT, and saturates it to OUT_W bits. The result is returned over a
// valid/ready handshake.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   len        products per run, sampled on the first beat (0 is treated as 1)
//   in_valid   in_prod is valid
//   in_ready   a product is accepted this cycle (IDLE or ACC)
//   in_prod    signed NP-bit product
//   out_valid  out_data / out_sat are valid
//   out_ready  downstream accepts the result
//   out_data   rounded, shifted, saturated signed sum
//   out_sat    out_data was clipped to +max or -min
//   busy       block is in any state other than IDLE
//
// ACC_W must be >= NP+LEN_W so that a full-length run can never overflow the
// accumulator.
// -----------------------------------------------------------------------------
module lib_acc_round_sat #(
    parameter int NP    = 34,
    parameter int LEN_W = 8,
    parameter int ACC_W = 42,
    parameter int SHIFT = 8,
    parameter int OUT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NP-1:0]    in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RND  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Half of one output LSB, added before the shift (nothing when SHIFT==0).
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_W:0] RND_ADD =
        (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_POS) : '0;

    // Output range expressed in the (ACC_W+1)-bit rounding domain.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    state_t                   r_state;
    state_t                   w_state_next;
    logic signed [ACC_W-1:0]  r_acc;
    logic [LEN_W-1:0]         r_len;
    logic [LEN_W-1:0]         r_cnt;
    logic [OUT_W-1:0]         r_out_data;
    logic                     r_out_sat;

    logic                     w_beat;
    logic                     w_hs_out;
    logic [ACC_W-1:0]         w_prod_ext;
    logic [LEN_W-1:0]         w_len_eff;
    logic [LEN_W-1:0]         w_cnt_inc;
    logic                     w_last;
    logic signed [ACC_W:0]    w_t;
    logic signed [ACC_W:0]    w_r;
    logic [OUT_W-1:0]         w_rnd_data;
    logic                     w_rnd_sat;

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_ACC);
    assign out_valid  = (r_state == S_OUT);
    assign busy       = (r_state != S_IDLE);
    assign out_data   = r_out_data;
    assign out_sat    = r_out_sat;

    assign w_beat     = in_valid & in_ready;
    assign w_hs_out   = out_valid & out_ready;
    assign w_prod_ext = {{(ACC_W - NP){in_prod[NP-1]}}, in_prod};
    assign w_len_eff  = (len == '0) ? LEN_W'(1) : len;
    assign w_cnt_inc  = r_cnt + LEN_W'(1);
    // In ACC, the beat that brings the count up to L is the last one.
    assign w_last     = (w_cnt_inc == r_len);

    // Round half-up. One guard bit keeps the add from overflowing. The
    // arithmetic shift floors, so ties resolve toward +inf.
    assign w_t = {r_acc[ACC_W-1], r_acc} + RND_ADD;
    assign w_r = w_t >>> SHIFT;

    always_comb begin
        w_rnd_data = w_r[OUT_W-1:0];
        w_rnd_sat  = 1'b0;
        if (w_r > SAT_MAX) begin
            w_rnd_data = {1'b0, {(OUT_W - 1){1'b1}}};
            w_rnd_sat  = 1'b1;
        end else if (w_r < SAT_MIN) begin
            w_rnd_data = {1'b1, {(OUT_W - 1){1'b0}}};
            w_rnd_sat  = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    w_state_next = (w_len_eff == LEN_W'(1)) ? S_RND : S_ACC;
                end
            end
            S_ACC: begin
                if (w_beat && w_last) begin
                    w_state_next = S_RND;
                end
            end
            S_RND: begin
                w_state_next = S_OUT;
            end
            S_OUT: begin
                if (w_hs_out) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_beat) begin
                        r_acc <= w_prod_ext;
                        r_cnt <= LEN_W'(1);
                        r_len <= w_len_eff;
                    end
                end
                S_ACC: begin
                    if (w_beat) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RND: begin
                    r_out_data <= w_rnd_data;
                    r_out_sat  <= w_rnd_sat;
                end
                S_OUT: begin
                    if (w_hs_out) begin
                        r_acc <= '0;
                    end
                end
                default: begin
                    r_acc <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lib_acc_round_sat.sv
module tb_lib_acc_round_sat;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_data;
    logic        out_sat;
    logic        busy;

    int checks = 0;
    int errors = 0;

    lib_acc_round_sat dut (
        .clk       (clk),
        .rst       (rst),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]        len;
        logic [3:0][33:0]  p;
        logic [25:0]       ed;
        logic              es;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [7:0] l, input longint a, input longint b,
                                input longint c, input longint d,
                                input logic [25:0] ed, input logic es);
        vec_t v;
        v.len  = l;
        v.p[0] = 34'(a);
        v.p[1] = 34'(b);
        v.p[2] = 34'(c);
        v.p[3] = 34'(d);
        v.ed   = ed;
        v.es   = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Presents nb beats (all of the run when nb<0), with gap idle cycles
    // before each beat. len is scrambled after the first beat.
    task automatic feed_run(input logic [7:0] l, input logic [3:0][33:0] p,
                            input int gap, input int nb);
        int n;
        int t;
        n = (l == 8'd0) ? 1 : int'(l);
        if (nb >= 0) n = nb;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_prod  = 34'h2DEADBEEF;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_prod  = p[i];
            len      = (i == 0) ? l : 8'hFF;
            t = 0;
            while (!in_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_prod  = '0;
    endtask

    task automatic run_vec(input int id, input vec_t v, input int gap);
        feed_run(v.len, v.p, gap, -1);
        chk($sformatf("v%0d_rnd_valid", id), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d_rnd_ready", id), 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid", id), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d_data", id), 64'(out_data), 64'(v.ed));
        chk($sformatf("v%0d_sat", id), 64'(out_sat), 64'(v.es));
        $display("run %0d len=%0d gap=%0d out_data=%h out_sat=%b", id, v.len, gap, out_data, out_sat);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid_drop", id), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d_idle", id), 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic quiet;

        vecs[0]  = mk(8'd1, 256, 0, 0, 0, 26'h0000001, 1'b0);
        vecs[1]  = mk(8'd3, 100, -300, 456, 0, 26'h0000001, 1'b0);
        vecs[2]  = mk(8'd2, 200, 184, 0, 0, 26'h0000002, 1'b0);
        vecs[3]  = mk(8'd2, -200, -184, 0, 0, 26'h3FFFFFF, 1'b0);
        vecs[4]  = mk(8'd4, 64'sd4294967296, 64'sd4294967296, 64'sd4294967296,
                      64'sd4294967296, 26'h1FFFFFF, 1'b1);
        vecs[5]  = mk(8'd4, -64'sd4294967296, -64'sd4294967296, -64'sd4294967296,
                      -64'sd4294967296, 26'h2000000, 1'b1);
        vecs[6]  = mk(8'd0, -256, 0, 0, 0, 26'h3FFFFFF, 1'b0);
        vecs[7]  = mk(8'd1, 384, 0, 0, 0, 26'h0000002, 1'b0);
        vecs[8]  = mk(8'd1, -384, 0, 0, 0, 26'h3FFFFFF, 1'b0);
        vecs[9]  = mk(8'd1, -640, 0, 0, 0, 26'h3FFFFFE, 1'b0);
        vecs[10] = mk(8'd1, 64'sd8589934336, 0, 0, 0, 26'h1FFFFFF, 1'b0);
        vecs[11] = mk(8'd1, 64'sd8589934463, 0, 0, 0, 26'h1FFFFFF, 1'b0);
        vecs[12] = mk(8'd1, 64'sd8589934464, 0, 0, 0, 26'h1FFFFFF, 1'b1);
        vecs[13] = mk(8'd1, -64'sd8589934592, 0, 0, 0, 26'h2000000, 1'b0);
        vecs[14] = mk(8'd2, -64'sd8589934592, -129, 0, 0, 26'h2000000, 1'b1);

        rst       = 1'b1;
        len       = 8'd1;
        in_valid  = 1'b1;
        in_prod   = 34'd256;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < NV; k++) run_vec(k, vecs[k], 0);

        // The same three-beat run with 3-cycle gaps gives the same result.
        run_vec(100, vecs[1], 3);

        // Result held under backpressure with the input blocked.
        out_ready = 1'b0;
        v = mk(8'd2, 512, 512, 0, 0, 26'h0000004, 1'b0);
        feed_run(v.len, v.p, 0, -1);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_prod  = 34'd999;
            chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d_data", c), 64'(out_data), 64'd4);
            chk($sformatf("bp%0d_ready", c), 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        $display("backpressure run out_data=%h out_sat=%b", out_data, out_sat);
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_busy", 64'(busy), 64'd0);
        quiet = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid) quiet = 1'b0;
        end
        chk("bp_single_result", 64'(quiet), 64'd1);

        // Reset mid-run aborts the run and leaves the accumulator clean.
        v = mk(8'd4, 1000, 2000, 3000, 4000, 26'h0, 1'b0);
        feed_run(v.len, v.p, 0, 2);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 34'd777;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        quiet = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) quiet = 1'b0;
        end
        chk("abort_no_result", 64'(quiet), 64'd1);
        $display("abort run: no result emitted=%b", quiet);
        run_vec(200, mk(8'd1, 512, 0, 0, 0, 26'h0000002, 1'b0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
